sram_ref_dds: RTL and testbench

Reference-waveform generator for the lock-in datapath. It sits directly downstream of the flash-to-SRAM loader and reads the 65536-entry, 16-bit signed waveform table that the loader writes into SRAM. A 32-bit phase accumulator indexes the table; for every sample strobe the block fetches an in-phase (I) word and a quadrature (Q) word, the Q word a quarter table later. It presents the pair to the demodulator multipliers as a registered sin/cos output. It stays silent while the loader owns the SRAM.

---
 rtl/sram_ref_dds_pkg.sv | 20 ++
 rtl/sram_ref_dds_if.sv | 31 +++
 rtl/sram_ref_dds_phase.sv | 45 ++++
 rtl/sram_ref_dds.sv | 117 +++++++++++
 tb/tb_sram_ref_dds.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ref_dds_pkg.sv
// Shared widths, default quarter-period offset and FSM encoding for the reference DDS.
package sram_ref_dds_pkg;

  localparam int unsigned TABLE_AW = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PHASE_W  = 32;

  // Quarter period of a 65536-entry table: Q leads I by 90 degrees.
  localparam logic [TABLE_AW-1:0] QUARTER_DEFAULT = 16'h4000;

  typedef enum logic [2:0] {
    StIdle,
    StReqI,
    StWaitI,
    StReqQ,
    StWaitQ,
    StPublish
  } state_e;

endpackage

// File: rtl/sram_ref_dds_if.sv
// Sample strobe, tuning words, SRAM read port and sin/cos result of the reference DDS.
interface sram_ref_dds_if;
  import sram_ref_dds_pkg::*;

  logic                sample_en;
  logic [PHASE_W-1:0]  ftw;
  logic [TABLE_AW-1:0] pow;
  logic                load_busy;
  logic                rd_req;
  logic [TABLE_AW-1:0] rd_addr;
  logic                rd_ack;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   sin_out;
  logic [DATA_W-1:0]   cos_out;
  logic                out_valid;
  logic                overrun;

  // DDS side
  modport master (
    input  sample_en, ftw, pow, load_busy, rd_ack, rd_valid, rd_data,
    output rd_req, rd_addr, sin_out, cos_out, out_valid, overrun
  );

  // Environment side: sample source, SRAM port and demodulator
  modport slave (
    output sample_en, ftw, pow, load_busy, rd_ack, rd_valid, rd_data,
    input  rd_req, rd_addr, sin_out, cos_out, out_valid, overrun
  );

endinterface

// File: rtl/sram_ref_dds_phase.sv
// Phase accumulator plus table-address generation for the I and Q reads.
module sram_ref_dds_phase
  import sram_ref_dds_pkg::*;
#(
  parameter logic [TABLE_AW-1:0] QUARTER = QUARTER_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sample_en_i,
  input  logic                fetch_start_i,
  input  logic [PHASE_W-1:0]  ftw_i,
  input  logic [TABLE_AW-1:0] pow_i,
  output logic [TABLE_AW-1:0] base_next_o,
  output logic [TABLE_AW-1:0] q_addr_o
);

  logic [PHASE_W-1:0]  phase_q, phase_d, phase_sum;
  logic [TABLE_AW-1:0] base_q, base_d;
  logic [TABLE_AW-1:0] fetch_base_q, fetch_base_d;

  // Next phase/base; base uses the already-advanced phase. Fetch base is frozen per fetch so a
  // strobe arriving mid-fetch cannot move the pending Q address.
  always_comb begin
    phase_sum    = phase_q + ftw_i;
    base_next_o  = phase_sum[PHASE_W-1:PHASE_W-TABLE_AW] + pow_i;
    phase_d      = sample_en_i ? phase_sum : phase_q;
    base_d       = sample_en_i ? base_next_o : base_q;
    fetch_base_d = fetch_start_i ? base_next_o : fetch_base_q;
    q_addr_o     = fetch_base_q + QUARTER;
  end

  // Accumulator and address registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q      <= '0;
      base_q       <= '0;
      fetch_base_q <= '0;
    end else begin
      phase_q      <= phase_d;
      base_q       <= base_d;
      fetch_base_q <= fetch_base_d;
    end
  end

endmodule

// File: rtl/sram_ref_dds.sv
// Reference sin/cos generator: reads I and Q words from the shared SRAM table per sample strobe.
module sram_ref_dds
  import sram_ref_dds_pkg::*;
#(
  parameter logic [TABLE_AW-1:0] QUARTER = QUARTER_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  sram_ref_dds_if.master bus
);

  state_e              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [TABLE_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   i_word_q, i_word_d;
  logic [DATA_W-1:0]   q_word_q, q_word_d;
  logic [DATA_W-1:0]   sin_q, sin_d;
  logic [DATA_W-1:0]   cos_q, cos_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                zero_q, zero_d;
  logic                fetch_start;
  logic [TABLE_AW-1:0] base_next;
  logic [TABLE_AW-1:0] q_addr;

  assign fetch_start = bus.sample_en && (state_q == StIdle) && !bus.load_busy;

  sram_ref_dds_phase #(
    .QUARTER (QUARTER)
  ) u_phase (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_en_i   (bus.sample_en),
    .fetch_start_i (fetch_start),
    .ftw_i         (bus.ftw),
    .pow_i         (bus.pow),
    .base_next_o   (base_next),
    .q_addr_o      (q_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.sample_en) state_d = bus.load_busy ? StPublish : StReqI;
      StReqI:    if (bus.rd_ack)    state_d = StWaitI;
      StWaitI:   if (bus.rd_valid)  state_d = StReqQ;
      StReqQ:    if (bus.rd_ack)    state_d = StWaitQ;
      StWaitQ:   if (bus.rd_valid)  state_d = StPublish;
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and fetch holding registers
  always_comb begin
    rd_req_d    = (state_d == StReqI) || (state_d == StReqQ);
    rd_addr_d   = rd_addr_q;
    i_word_d    = i_word_q;
    q_word_d    = q_word_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    out_valid_d = (state_q == StPublish);
    overrun_d   = overrun_q || (bus.sample_en && (state_q != StIdle));
    // Zeroing flag: captured at the strobe, then ORed with any load_busy seen during the fetch.
    zero_d      = (state_q == StIdle) ? bus.load_busy : (zero_q || bus.load_busy);

    if ((state_q == StIdle) && (state_d == StReqI))   rd_addr_d = base_next;
    if ((state_q == StWaitI) && (state_d == StReqQ))  rd_addr_d = q_addr;
    if ((state_q == StWaitI) && bus.rd_valid)         i_word_d  = bus.rd_data;
    if ((state_q == StWaitQ) && bus.rd_valid)         q_word_d  = bus.rd_data;

    if (state_q == StPublish) begin
      sin_d = (zero_q || bus.load_busy) ? '0 : i_word_q;
      cos_d = (zero_q || bus.load_busy) ? '0 : q_word_q;
    end
  end

  // Output and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      i_word_q    <= '0;
      q_word_q    <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      i_word_q    <= i_word_d;
      q_word_q    <= q_word_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sram_ref_dds.sv
// Directed bench for sram_ref_dds with an SRAM model whose table holds table[n] = n.
module tb_sram_ref_dds;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ref_dds_if bus ();

  sram_ref_dds #(
    .QUARTER (16'h4000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: ack after ack_dly cycles of rd_req, data lat cycles after ack.
  int          ack_dly;
  int          lat;
  int          req_cnt = 0;
  int          dcnt = 0;
  logic [15:0] daddr = '0;
  logic        stray_valid;

  assign bus.rd_ack   = bus.rd_req && (req_cnt == ack_dly);
  assign bus.rd_valid = (dcnt == 1) || stray_valid;
  assign bus.rd_data  = daddr;

  always @(posedge clk) begin
    if (rst || !bus.rd_req || bus.rd_ack) req_cnt <= 0;
    else                                  req_cnt <= req_cnt + 1;
    if (rst)                                 dcnt <= 0;
    else if (bus.rd_req && bus.rd_ack) begin
      dcnt  <= lat;
      daddr <= bus.rd_addr;
    end else if (dcnt > 0)                   dcnt <= dcnt - 1;
  end

  // Monitor of accepted addresses and output pulses
  int          ack_cnt = 0;
  int          ov_cnt = 0;
  logic [15:0] last_prev = '0;
  logic [15:0] last_cur = '0;

  always @(posedge clk) begin
    if (bus.rd_req && bus.rd_ack) begin
      ack_cnt   <= ack_cnt + 1;
      last_prev <= last_cur;
      last_cur  <= bus.rd_addr;
    end
    if (bus.out_valid === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe during the current cycle; returns in cycle 1 after the strobe.
  task automatic strobe();
    bus.sample_en = 1'b1;
    tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic wait_ov(input int start, output int cyc);
    cyc = start;
    while ((bus.out_valid !== 1'b1) && (cyc < 60)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int acks;
    int ovs;

    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.ftw       = '0;
    bus.pow       = '0;
    bus.load_busy = 1'b0;
    stray_valid   = 1'b0;
    ack_dly       = 0;
    lat           = 1;
    ticks(2);

    // Reset state
    chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_sin", 32'(bus.sin_out), 32'd0);
    chk("rst_cos", 32'(bus.cos_out), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;

    // Zero-wait SRAM, strobe every 10 cycles
    bus.ftw = 32'h0001_0000;
    for (int k = 1; k <= 3; k++) begin
      strobe();
      chk("t1_rd_req", 32'(bus.rd_req), 32'd1);
      chk("t1_i_addr", 32'(bus.rd_addr), 32'(k));
      wait_ov(1, cyc);
      chk("t1_latency", 32'(cyc), 32'd6);
      chk("t1_sin", 32'(bus.sin_out), 32'(k));
      chk("t1_cos", 32'(bus.cos_out), 32'h4000 + 32'(k));
      chk("t1_acked_i", 32'(last_prev), 32'(k));
      chk("t1_acked_q", 32'(last_cur), 32'h4000 + 32'(k));
      tick();
      chk("t1_ov_pulse", 32'(bus.out_valid), 32'd0);
      ticks(3);
    end
    chk("t1_overrun", 32'(bus.overrun), 32'd0);

    // Reset during REQ_Q, then a stray rd_valid
    strobe();
    ticks(2);
    chk("t6_in_req_q", 32'(bus.rd_req), 32'd1);
    chk("t6_q_addr", 32'(bus.rd_addr), 32'h4004);
    rst = 1'b1;
    tick();
    chk("t6_rd_req", 32'(bus.rd_req), 32'd0);
    chk("t6_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("t6_sin", 32'(bus.sin_out), 32'd0);
    chk("t6_cos", 32'(bus.cos_out), 32'd0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    ovs = ov_cnt;
    stray_valid = 1'b1;
    tick();
    stray_valid = 1'b0;
    ticks(4);
    chk("t6_stray_ov", 32'(ov_cnt), 32'(ovs));
    strobe();
    wait_ov(1, cyc);
    chk("t6_restart_lat", 32'(cyc), 32'd6);
    chk("t6_restart_sin", 32'(bus.sin_out), 32'd1);
    ticks(4);

    // Phase and base wrap-around
    do_reset();
    bus.ftw = 32'hFFFF_0000;
    strobe();
    chk("t2_i_ffff", 32'(bus.rd_addr), 32'hFFFF);
    wait_ov(1, cyc);
    chk("t2_sin_ffff", 32'(bus.sin_out), 32'hFFFF);
    chk("t2_cos_3fff", 32'(bus.cos_out), 32'h3FFF);
    ticks(4);
    bus.ftw = 32'h0001_0000;
    strobe();
    chk("t2_i_0000", 32'(bus.rd_addr), 32'h0000);
    wait_ov(1, cyc);
    chk("t2_sin_0000", 32'(bus.sin_out), 32'h0000);
    chk("t2_cos_4000", 32'(bus.cos_out), 32'h4000);
    ticks(4);
    bus.pow = 16'hFFFE;
    strobe();
    chk("t2_pow_wrap", 32'(bus.rd_addr), 32'hFFFF);
    wait_ov(1, cyc);
    chk("t2_pow_cos", 32'(bus.cos_out), 32'h3FFF);
    bus.pow = '0;
    ticks(4);

    // Slow SRAM, strobe every 6 cycles
    do_reset();
    ack_dly = 3;
    lat     = 2;
    strobe();
    chk("t3_overrun_0", 32'(bus.overrun), 32'd0);
    ticks(5);
    strobe();
    chk("t3_overrun_1", 32'(bus.overrun), 32'd1);
    ticks(5);
    strobe();
    chk("t3_no_ov_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t3_ov", 32'(bus.out_valid), 32'd1);
    chk("t3_sin", 32'(bus.sin_out), 32'd1);
    chk("t3_cos", 32'(bus.cos_out), 32'h4001);
    chk("t3_acked_i", 32'(last_prev), 32'd1);
    chk("t3_acked_q", 32'(last_cur), 32'h4001);
    ticks(4);
    strobe();
    chk("t3_phase_adv", 32'(bus.rd_addr), 32'd4);
    wait_ov(1, cyc);
    chk("t3_latency", 32'(cyc), 32'd14);
    chk("t3_sin2", 32'(bus.sin_out), 32'd4);
    chk("t3_cos2", 32'(bus.cos_out), 32'h4004);
    chk("t3_sticky", 32'(bus.overrun), 32'd1);
    ticks(4);

    // load_busy high before the strobe
    do_reset();
    ack_dly = 0;
    lat     = 1;
    chk("t4_overrun_clr", 32'(bus.overrun), 32'd0);
    strobe();
    wait_ov(1, cyc);
    chk("t4_pre_sin", 32'(bus.sin_out), 32'd1);
    ticks(4);
    bus.load_busy = 1'b1;
    tick();
    acks = ack_cnt;
    strobe();
    chk("t4_no_req", 32'(bus.rd_req), 32'd0);
    wait_ov(1, cyc);
    chk("t4_latency", 32'(cyc), 32'd2);
    chk("t4_sin", 32'(bus.sin_out), 32'd0);
    chk("t4_cos", 32'(bus.cos_out), 32'd0);
    chk("t4_no_acks", 32'(ack_cnt), 32'(acks));
    tick();
    bus.load_busy = 1'b0;
    ticks(3);

    // load_busy pulse during WAIT_I
    strobe();
    wait_ov(1, cyc);
    chk("t5_pre_cos", 32'(bus.cos_out), 32'h4003);
    ticks(4);
    acks = ack_cnt;
    strobe();
    tick();
    bus.load_busy = 1'b1;
    tick();
    bus.load_busy = 1'b0;
    wait_ov(3, cyc);
    chk("t5_latency", 32'(cyc), 32'd6);
    chk("t5_sin", 32'(bus.sin_out), 32'd0);
    chk("t5_cos", 32'(bus.cos_out), 32'd0);
    chk("t5_acks", 32'(ack_cnt), 32'(acks + 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
